// File: rtl/key_pio_irq_servicer.sv
// Services the 4-bit key PIO in hardware: programs irq_mask, reads and clears edge_capture on irq,
// and turns accepted edges into one-cycle key_event pulses with a per-key lockout.
module key_pio_irq_servicer #(
    parameter int NUM_KEYS     = 4,
    parameter int LOCKOUT_CYC  = 500000,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] cfg_mask,
    input  logic                cfg_load,
    output logic [1:0]          avm_address,
    output logic                avm_chipselect,
    output logic                avm_write_n,
    output logic [31:0]         avm_writedata,
    input  logic [31:0]         avm_readdata,
    input  logic                pio_irq,
    output logic [NUM_KEYS-1:0] key_event,
    output logic [NUM_KEYS-1:0] lockout_active,
    output logic                busy,
    output logic [2:0]          state_dbg
);

    localparam int CNT_W = $clog2(LOCKOUT_CYC + 1);
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] LOCK_RELOAD = CNT_W'(LOCKOUT_CYC);
    localparam logic [LAT_W-1:0] LAT_RELOAD  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_CLR  = 3'd4,
        S_EMIT = 3'd5
    } state_t;

    state_t              state;
    logic [NUM_KEYS-1:0] mask;
    logic [NUM_KEYS-1:0] pend_mask;
    logic                pend_load;
    logic [NUM_KEYS-1:0] cap;
    logic [LAT_W-1:0]    lat_cnt;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];

    logic [NUM_KEYS-1:0] load_mask;
    logic [NUM_KEYS-1:0] rd_cap;
    logic [NUM_KEYS-1:0] accept;
    logic                unused_readdata;

    assign state_dbg       = state;
    assign load_mask       = cfg_load ? cfg_mask : pend_mask;
    assign rd_cap          = avm_readdata[NUM_KEYS-1:0] & mask;
    assign accept          = (state == S_CLR) ? (cap & ~lockout_active) : '0;
    assign unused_readdata = ^avm_readdata[31:NUM_KEYS];

    // Bus: the PIO has no waitrequest, so an access is exactly one cycle with
    // chipselect high (write_n low = write); at most one access is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_INIT;
            mask           <= '1;
            pend_mask      <= '0;
            pend_load      <= 1'b0;
            cap            <= '0;
            lat_cnt        <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 2'd0;
            avm_writedata  <= 32'd0;
            key_event      <= '0;
            busy           <= 1'b1;
        end else begin
            key_event <= '0;
            if (cfg_load) begin
                pend_load <= 1'b1;
                pend_mask <= cfg_mask;
            end
            case (state)
                // Entered from reset with chipselect low (issue the write), or
                // from IDLE with the write already on the bus (finish it).
                S_INIT: begin
                    if (!avm_chipselect) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= 2'd2;
                        avm_writedata  <= {{(32-NUM_KEYS){1'b0}}, mask};
                    end else begin
                        avm_chipselect <= 1'b0;
                        avm_write_n    <= 1'b1;
                        busy           <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (cfg_load || pend_load) begin
                        mask           <= load_mask;
                        pend_load      <= 1'b0;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= 2'd2;
                        avm_writedata  <= {{(32-NUM_KEYS){1'b0}}, load_mask};
                        busy           <= 1'b1;
                        state          <= S_INIT;
                    end else if (pio_irq) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b1;
                        avm_address    <= 2'd3;
                        busy           <= 1'b1;
                        state          <= S_RD;
                    end
                end
                S_RD: begin
                    avm_chipselect <= 1'b0;
                    lat_cnt        <= LAT_RELOAD;
                    state          <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        cap            <= rd_cap;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= 2'd3;
                        avm_writedata  <= {{(32-NUM_KEYS){1'b0}}, rd_cap};
                        state          <= S_CLR;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_CLR: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    key_event      <= accept;
                    state          <= S_EMIT;
                end
                // An edge that landed while the capture was being cleared is picked up by another read.
                S_EMIT: begin
                    if (pio_irq) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b1;
                        avm_address    <= 2'd3;
                        state          <= S_RD;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    busy           <= 1'b1;
                    state          <= S_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (accept[i]) begin
                    cnt[i] <= LOCK_RELOAD;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        lockout_active = '0;
        for (int i = 0; i < NUM_KEYS; i++) lockout_active[i] = (cnt[i] != '0);
    end

endmodule

// File: tb/tb_key_pio_irq_servicer.sv
// Bench for key_pio_irq_servicer: a PIO edge-capture model on the bus, directed vector table,
// hand-written multi-cycle sequences, and a randomized run against a lockout/mask reference model.
module tb_key_pio_irq_servicer;

    localparam int NK      = 4;
    localparam int LCYC    = 16;
    localparam int RL      = 1;
    // One edge for the PIO to capture, then irq-in-IDLE at N gives key_event at N+3+RL.
    localparam int EVT_LAT = 4 + RL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] cfg_mask = '0;
    logic          cfg_load = 1'b0;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;
    logic          pio_irq;
    logic [NK-1:0] key_event;
    logic [NK-1:0] lockout_active;
    logic          busy;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    key_pio_irq_servicer #(
        .NUM_KEYS    (NK),
        .LOCKOUT_CYC (LCYC),
        .READ_LATENCY(RL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_mask      (cfg_mask),
        .cfg_load      (cfg_load),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .pio_irq       (pio_irq),
        .key_event     (key_event),
        .lockout_active(lockout_active),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // PIO model: edge capture, irq mask, registered read data, write log.
    logic [NK-1:0] edge_cap;
    logic [NK-1:0] pio_mask;
    logic [NK-1:0] inj = '0;
    logic [31:0]   pio_rdata;
    logic [33:0]   wr_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap  <= '0;
            pio_mask  <= '0;
            pio_rdata <= '0;
        end else begin
            if (avm_chipselect && !avm_write_n) wr_q.push_back({avm_address, avm_writedata});
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2) pio_mask <= avm_writedata[NK-1:0];
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3) edge_cap <= inj;
            else edge_cap <= edge_cap | inj;
            if (avm_chipselect && avm_write_n)
                pio_rdata <= (avm_address == 2'd3) ? {28'd0, edge_cap} : {28'd0, pio_mask};
        end
    end
    assign avm_readdata = pio_rdata;
    assign pio_irq      = |(edge_cap & pio_mask);

    // Scoreboard
    int total = 0;
    int bad   = 0;
    logic [NK-1:0] exp_q[$];

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inj(input logic [NK-1:0] p);
        inj = p;
        tick();
        inj = '0;
    endtask

    // Watches n samples starting with the current one; n edges in total per call pair with pulse_inj.
    task automatic observe(input int n, output logic [NK-1:0] ev_or, output int pulses, output int first_k);
        ev_or = '0;
        pulses = 0;
        first_k = 0;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) tick();
            if (key_event != '0) begin
                ev_or = ev_or | key_event;
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
    endtask

    task automatic check_writes(input string name, input int n, input logic [33:0] w0, input logic [33:0] w1,
                                input logic [33:0] w2);
        logic [33:0] exp_w[3];
        exp_w[0] = w0;
        exp_w[1] = w1;
        exp_w[2] = w2;
        check({name, "_nwr"}, 34'(wr_q.size()), 34'(n));
        for (int i = 0; i < n && wr_q.size() > 0; i++) check($sformatf("%s_wr%0d", name, i), wr_q.pop_front(), exp_w[i]);
        wr_q.delete();
    endtask

    typedef struct {
        logic [NK-1:0] inj;
        int            gap;
        logic [NK-1:0] exp_evt;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        vec_t          vecs[7];
        logic [NK-1:0] ev, ev_a, ev_b, rmask, pat, expv;
        int            np, fk, ka, kb, idle_gaps, lk, gap, now, nwr;
        logic          lock_at_evt;
        int            last_acc[NK];

        // Directed vectors, LOCKOUT 16: a key fires only if >16 cycles since its last accepted edge.
        vecs[0] = '{4'h4, 8,  4'h4};   // first key 2 edge
        vecs[1] = '{4'h4, 20, 4'h0};   // 8 after accept: locked out
        vecs[2] = '{4'h4, 12, 4'h4};   // 28 after accept: fires
        vecs[3] = '{4'h1, 12, 4'h1};
        vecs[4] = '{4'h3, 12, 4'h2};   // key 0 still locked (12), key 1 fresh
        vecs[5] = '{4'hF, 20, 4'hD};   // key 1 locked (12), others clear
        vecs[6] = '{4'h2, 12, 4'h2};

        // Reset state and INIT write
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 34'(avm_chipselect), 34'd0);
        check("rst_wr_n", 34'(avm_write_n), 34'd1);
        check("rst_addr", 34'(avm_address), 34'd0);
        check("rst_wdata", 34'(avm_writedata), 34'd0);
        check("rst_event", 34'(key_event), 34'd0);
        check("rst_lock", 34'(lockout_active), 34'd0);
        check("rst_busy", 34'(busy), 34'd1);
        reset = 1'b0;
        tick();
        check("init_cs", 34'(avm_chipselect), 34'd1);
        check("init_wr_n", 34'(avm_write_n), 34'd0);
        check("init_addr", 34'(avm_address), 34'd2);
        check("init_wdata", 34'(avm_writedata), 34'hF);
        check("init_busy", 34'(busy), 34'd1);
        tick();
        check("init_busy_low", 34'(busy), 34'd0);
        check("init_cs_low", 34'(avm_chipselect), 34'd0);
        check_writes("init", 1, {2'd2, 32'hF}, '0, '0);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            pulse_inj(vecs[i].inj);
            observe(vecs[i].gap, ev, np, fk);
            check($sformatf("vec%0d_event", i), 34'(ev), 34'(vecs[i].exp_evt));
            if (vecs[i].exp_evt != '0) begin
                check($sformatf("vec%0d_latency", i), 34'(fk), 34'(EVT_LAT));
                check($sformatf("vec%0d_pulses", i), 34'(np), 34'd1);
            end
            check_writes($sformatf("vec%0d", i), 1, {2'd3, 28'd0, vecs[i].inj}, '0, '0);
        end

        // Lockout window length
        repeat (20) tick();
        wr_q.delete();
        pulse_inj(4'h8);
        ev = '0;
        lk = 0;
        lock_at_evt = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) tick();
            if (key_event[3]) lock_at_evt = lockout_active[3];
            ev = ev | key_event;
            if (lockout_active[3]) lk++;
        end
        check("lock_event", 34'(ev), 34'h8);
        check("lock_at_event", 34'(lock_at_evt), 34'd1);
        check("lock_cycles", 34'(lk), 34'(LCYC));
        wr_q.delete();

        // Edge landing as the capture is cleared: second read pass
        repeat (20) tick();
        wr_q.delete();
        pulse_inj(4'h2);
        ev_a = '0; ev_b = '0; ka = 0; kb = 0; idle_gaps = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) tick();
            inj = (k == 4) ? 4'h1 : 4'h0;
            if (key_event != '0) begin
                if (ka == 0) begin ka = k; ev_a = key_event; end
                else if (kb == 0) begin kb = k; ev_b = key_event; end
            end
            if (k >= 2 && k <= 9 && !busy) idle_gaps++;
        end
        inj = '0;
        check("reread_ev1", 34'(ev_a), 34'h2);
        check("reread_k1", 34'(ka), 34'(EVT_LAT));
        check("reread_ev2", 34'(ev_b), 34'h1);
        check("reread_k2", 34'(kb), 34'(EVT_LAT + 3 + RL));
        check("reread_busy", 34'(idle_gaps), 34'd0);
        check_writes("reread", 2, {2'd3, 32'h2}, {2'd3, 32'h1}, '0);

        // cfg_load together with irq, then pending loads during service
        repeat (20) tick();
        wr_q.delete();
        pulse_inj(4'h9);
        cfg_mask = 4'h3;
        cfg_load = 1'b1;
        ev = '0; np = 0; fk = 0;
        for (int k = 2; k <= 14; k++) begin
            tick();
            cfg_load = (k == 4 || k == 5);
            cfg_mask = (k == 4) ? 4'hE : 4'hF;
            if (key_event != '0) begin
                ev = ev | key_event;
                np++;
                if (fk == 0) fk = k;
            end
        end
        cfg_load = 1'b0;
        check("cfgirq_event", 34'(ev), 34'h1);
        check("cfgirq_k", 34'(fk), 34'(3 + 3 + RL));
        check("cfgirq_pulses", 34'(np), 34'd1);
        check_writes("cfgirq", 3, {2'd2, 32'h3}, {2'd3, 32'h1}, {2'd2, 32'hF});

        // Reset during WAIT with a pending cfg_load
        repeat (20) tick();
        wr_q.delete();
        pulse_inj(4'h2);
        tick();
        cfg_mask = 4'h3;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_cs", 34'(avm_chipselect), 34'd0);
        check("midrst_wr_n", 34'(avm_write_n), 34'd1);
        check("midrst_busy", 34'(busy), 34'd1);
        repeat (2) tick();
        reset = 1'b0;
        wr_q.delete();
        observe(12, ev, np, fk);
        check("midrst_event", 34'(ev), 34'd0);
        check_writes("midrst", 1, {2'd2, 32'hF}, '0, '0);

        // Randomized run against the reference model
        repeat (20) tick();
        rmask = 4'($urandom_range(1, 15));
        cfg_mask = rmask;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (4) tick();
        check_writes("rand_cfg", 1, {2'd2, 28'd0, rmask}, '0, '0);
        for (int k = 0; k < NK; k++) last_acc[k] = -1000;
        now = 0;
        for (int it = 0; it < 30; it++) begin
            pat = 4'($urandom_range(1, 15));
            gap = $urandom_range(10, 40);
            if (gap >= LCYC - 1 && gap <= LCYC + 2) gap += 4;
            expv = '0;
            for (int k = 0; k < NK; k++) begin
                if (pat[k] && rmask[k] && (now - last_acc[k] > LCYC)) begin
                    expv[k] = 1'b1;
                    last_acc[k] = now;
                end
            end
            exp_q.push_back(expv);
            pulse_inj(pat);
            observe(gap, ev, np, fk);
            check($sformatf("rand%0d_event", it), 34'(ev), 34'(exp_q.pop_front()));
            nwr = ((pat & rmask) != '0) ? 1 : 0;
            check_writes($sformatf("rand%0d", it), nwr, {2'd3, 28'd0, pat & rmask}, '0, '0);
            now += gap;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
